// File: rtl/reg_wr_arbiter.sv
// reg_wr_arbiter: shares the single register-file write port between the
// ALU writeback (requester 0) and the load unit (requester 1).
//
// Ports:
//   clk, rst_n                 clock (rising edge), async active-low reset
//   req0_valid/addr/data       ALU writeback request
//   req0_ready                 combinational grant to requester 0
//   req1_valid/addr/data       load-unit writeback request
//   req1_ready                 combinational grant to requester 1
//   wr_en/write_addr/write_data registered register-file write, 1 cycle after grant
//   pc_load/pc_value           registered one-cycle pulse for writes to PC_ADDR
//   pending_mask               registers with a write waiting or in flight
//   conflict_cnt               saturating count of cycles with both requests valid
module reg_wr_arbiter #(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 4,
  parameter int PC_ADDR = 15
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 req0_valid,
  input  logic [ADDR_W-1:0]    req0_addr,
  input  logic [DATA_W-1:0]    req0_data,
  output logic                 req0_ready,
  input  logic                 req1_valid,
  input  logic [ADDR_W-1:0]    req1_addr,
  input  logic [DATA_W-1:0]    req1_data,
  output logic                 req1_ready,
  output logic                 wr_en,
  output logic [ADDR_W-1:0]    write_addr,
  output logic [DATA_W-1:0]    write_data,
  output logic                 pc_load,
  output logic [DATA_W-1:0]    pc_value,
  output logic [2**ADDR_W-1:0] pending_mask,
  output logic [15:0]          conflict_cnt
);

  typedef enum logic {
    LAST_REQ0 = 1'b0,
    LAST_REQ1 = 1'b1
  } grant_e;

  grant_e              last_grant;
  logic                any_grant;
  logic [ADDR_W-1:0]   gnt_addr;
  logic [DATA_W-1:0]   gnt_data;
  logic                gnt_is_pc;

  // On a conflict the requester that did not win last time goes first, so
  // neither side ever waits more than one cycle.
  always_comb begin
    req0_ready = req0_valid && (!req1_valid || (last_grant == LAST_REQ1));
    req1_ready = req1_valid && (!req0_valid || (last_grant == LAST_REQ0));
    any_grant  = req0_ready || req1_ready;
    gnt_addr   = req0_ready ? req0_addr : req1_addr;
    gnt_data   = req0_ready ? req0_data : req1_data;
    gnt_is_pc  = (gnt_addr == ADDR_W'(PC_ADDR));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant   <= LAST_REQ1;
      wr_en        <= 1'b0;
      write_addr   <= '0;
      write_data   <= '0;
      pc_load      <= 1'b0;
      pc_value     <= '0;
      conflict_cnt <= '0;
    end else begin
      wr_en   <= 1'b0;
      pc_load <= 1'b0;
      if (any_grant) begin
        last_grant <= req0_ready ? LAST_REQ0 : LAST_REQ1;
        if (gnt_is_pc) begin
          pc_load  <= 1'b1;
          pc_value <= gnt_data;
        end else begin
          wr_en      <= 1'b1;
          write_addr <= gnt_addr;
          write_data <= gnt_data;
        end
      end
      if (req0_valid && req1_valid && (conflict_cnt != '1))
        conflict_cnt <= conflict_cnt + 16'd1;
    end
  end

  // Waiting requests plus the write currently on the output stage.
  always_comb begin
    pending_mask = '0;
    if (req0_valid && !req0_ready) pending_mask[req0_addr]  = 1'b1;
    if (req1_valid && !req1_ready) pending_mask[req1_addr]  = 1'b1;
    if (wr_en)                     pending_mask[write_addr] = 1'b1;
    if (pc_load)                   pending_mask[PC_ADDR]    = 1'b1;
  end

endmodule
